// File: rtl/band_color_fader.sv
// Maps peak-bin indices to programmable RGB332 band colours with hold timeout back to background.
// Optional COLOR_FADE_EN: channel-wise fade toward the target colour, one LSB per step.
module band_color_fader #(
  parameter int unsigned SAMPLES     = 32,
  parameter int unsigned NUM_BANDS   = 3,
  parameter int unsigned STEP_DIV    = 4,
  parameter int unsigned HOLD_CYCLES = 1024,
  localparam int unsigned IW = $clog2(SAMPLES),
  localparam int unsigned AW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] index_holder,
  input  logic          index_valid,
  input  logic [7:0]    backgroundColor,
  input  logic          pal_we,
  input  logic [AW-1:0] pal_addr,
  input  logic [7:0]    pal_data,
  output logic [7:0]    outColor,
  output logic          fading
);

  localparam int unsigned PW = IW + AW + 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } stateT;

  stateT           state;
  stateT           stateNext;
  logic [AW-1:0]   bandReg;
  logic [AW-1:0]   bandNext;
  logic [HW-1:0]   holdCnt;
  logic [HW-1:0]   holdNext;
  logic [7:0]      palette [NUM_BANDS];
  logic [PW-1:0]   bandProd;
  logic [AW-1:0]   strobeBand;
  logic            palWrOk;
  logic [7:0]      target;

  // Bin index to band: index * NUM_BANDS / SAMPLES, truncating.
  assign bandProd   = PW'(index_holder) * PW'(NUM_BANDS);
  assign strobeBand = AW'(bandProd / PW'(SAMPLES));

  assign palWrOk = pal_we && ({1'b0, pal_addr} < (AW + 1)'(NUM_BANDS));
  assign target  = (state == ACTIVE) ? palette[bandReg] : backgroundColor;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_BANDS); i++) begin
        palette[AW'(i)] <= (i == 0)                  ? 8'hFF :
                           (i == int'(NUM_BANDS) - 1) ? 8'h3F : 8'h07;
      end
    end else if (palWrOk) begin
      palette[pal_addr] <= pal_data;
    end
  end

  // A strobe always wins over hold expiry and reloads the counter.
  always_comb begin
    stateNext = state;
    bandNext  = bandReg;
    holdNext  = holdCnt;
    unique case (state)
      IDLE: begin
        if (index_valid) begin
          stateNext = ACTIVE;
          bandNext  = strobeBand;
          holdNext  = HW'(HOLD_CYCLES - 1);
        end
      end
      ACTIVE: begin
        if (index_valid) begin
          bandNext = strobeBand;
          holdNext = HW'(HOLD_CYCLES - 1);
        end else if (holdCnt == '0) begin
          stateNext = IDLE;
        end else begin
          holdNext = holdCnt - HW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bandReg <= '0;
      holdCnt <= '0;
    end else begin
      state   <= stateNext;
      bandReg <= bandNext;
      holdCnt <= holdNext;
    end
  end

`ifdef COLOR_FADE_EN
  localparam int unsigned SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [SW-1:0] stepCnt;
  logic          stepTick;
  logic [7:0]    outNext;
  logic [7:0]    palAtBandNext;
  logic [7:0]    targetNext;

  function automatic logic [2:0] stepChan(input logic [2:0] cur, input logic [2:0] tgt);
    if (cur < tgt) return cur + 3'd1;
    if (cur > tgt) return cur - 3'd1;
    return cur;
  endfunction

  // fading is registered alongside outColor against the target that will be live next cycle.
  always_comb begin
    stepTick      = (stepCnt == SW'(STEP_DIV - 1));
    outNext       = outColor;
    if (stepTick) begin
      outNext = {stepChan(outColor[7:5], target[7:5]),
                 stepChan(outColor[4:2], target[4:2]),
                 2'(stepChan({1'b0, outColor[1:0]}, {1'b0, target[1:0]}))};
    end
    palAtBandNext = (palWrOk && (pal_addr == bandNext)) ? pal_data : palette[bandNext];
    targetNext    = (stateNext == ACTIVE) ? palAtBandNext : backgroundColor;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stepCnt  <= '0;
      outColor <= 8'h00;
      fading   <= 1'b0;
    end else begin
      stepCnt  <= stepTick ? '0 : stepCnt + SW'(1);
      outColor <= outNext;
      fading   <= (outNext != targetNext);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outColor <= 8'h00;
    end else begin
      outColor <= target;
    end
  end

  assign fading = 1'b0;
`endif

endmodule

// File: doc/band_color_fader.md
# band_color_fader

Clocked, parametrised successor to the combinational bin-to-colour mapper in the visualiser display path. It maps each completed peak-bin index to one of NUM_BANDS programmable RGB332 colours, fades the displayed colour toward the target one LSB per channel per step, and returns to the background colour after a hold timeout. It sits between the FFT peak-index stage and the pixel colour mux.

## Interface
- SAMPLES, 32: number of FFT bins; index width IW = $clog2(SAMPLES)
- NUM_BANDS, 3: colour bands, ≥2; palette address width AW = max(1, $clog2(NUM_BANDS))
- STEP_DIV, 4: clock cycles per fade step, ≥1
- HOLD_CYCLES, 1024: cycles after the last index_valid before reverting to background, ≥1

- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- index_holder  in  IW  peak-bin index, sampled when index_valid=1
- index_valid  in  1  one-cycle strobe: new index available (replaces old `done` level)
- backgroundColor  in  8  RGB332 idle colour, tracked live
- pal_we  in  1  palette write enable
- pal_addr  in  AW  palette entry
- pal_data  in  8  RGB332 palette data
- outColor  out  8  displayed RGB332 colour (registered)
- fading  out  1  1 while outColor ≠ current target

## Operation
- Band: band = (index_holder × NUM_BANDS) / SAMPLES, computed at width IW+AW+1, truncating; latched into band_reg on index_valid.
- Defaults give 0–10 → band 0, 11–21 → band 1, 22–31 → band 2.
- Palette reset values: entry 0 = 8'hFF, entry NUM_BANDS-1 = 8'h3F, all others = 8'h07.
- Palette write: on pal_we, entry pal_addr ← pal_data at the clock edge. Writes with pal_addr ≥ NUM_BANDS are ignored.
- State machine, two states:
  - IDLE: target = backgroundColor.
  - ACTIVE: target = palette[band_reg].
  - IDLE → ACTIVE on index_valid.
  - ACTIVE → ACTIVE on index_valid: band_reg updated, hold counter reloaded.
  - ACTIVE → IDLE when the hold counter is 0 and index_valid=0.
- Hold counter: loaded with HOLD_CYCLES-1 on index_valid, decremented each ACTIVE cycle. IDLE is entered HOLD_CYCLES cycles after the last strobe.
- Target is combinational from state, band_reg, palette and backgroundColor. A palette write to the active band, or a change of backgroundColor in IDLE, retargets the fade the next cycle.
- Fade:
  - step_cnt runs free 0..STEP_DIV-1 from reset.
  - On cycles where step_cnt = STEP_DIV-1, each channel of outColor (R[7:5], G[4:2], B[1:0]) moves one toward the matching target channel and holds once equal.
  - Channels step independently. There is no overshoot and no wrap.
- A new index mid-fade continues from the current outColor. step_cnt is not reset.
- fading = (outColor ≠ target), registered-consistent with outColor.

## Timing
- Reset (rst_n=0 at an edge): outColor=8'h00, fading=0 (target ignored during reset), state=IDLE, band_reg=0, hold counter=0, step_cnt=0, palette at its defaults.
- After reset, outColor fades from 8'h00 to backgroundColor.
- index_valid at edge N: state and band_reg update at N, so the new target is visible in cycle N+1. The first colour step occurs within STEP_DIV cycles.
- Worst-case fade completes within 7×STEP_DIV cycles (R/G span 7 steps).
- Reset asserted mid-fade or mid-hold aborts immediately to the reset values. The palette also returns to defaults.
- index_valid and hold expiry in the same cycle: the strobe wins, state stays ACTIVE and the counter reloads.
- pal_we and index_valid in the same cycle: both take effect. The target next cycle uses the new palette content.

## Configuration
- COLOR_FADE_EN defined: fade behaviour as above.
- Not defined: outColor ← target every cycle, so there is 1-cycle latency from a target change to outColor. fading is tied to 0 and step_cnt is removed. The state machine, hold timeout and palette are unchanged.

## Test plan
- Reset, backgroundColor=8'h00, index_valid with index 5, STEP_DIV=4 → target 8'hFF. outColor steps 00→25→4A→6F→…→FF (+1 per channel per step every 4 cycles). fading drops after 7 steps (28 cycles).
- Band boundaries, fade disabled: indices 10, 11, 21, 22, 31 → outColor 8'hFF, 07, 07, 3F, 3F one cycle after each strobe.
- Hold timeout, HOLD_CYCLES=16: one strobe then none → state returns to IDLE 16 cycles later and outColor fades to backgroundColor=8'h92. A strobe landing in the expiry cycle keeps ACTIVE.
- Palette: write entry 1 = 8'hE0 while band 1 is active → target changes next cycle and outColor fades to E0. A write to pal_addr=3 (NUM_BANDS=3) leaves the palette unchanged.
- Mid-fade retarget: index 0 (to FF), then after 8 cycles index 31 (to 3F) → fade proceeds from the current value with no jump. R decreases while G/B continue up or hold.
- rst_n low for one cycle mid-fade → next cycle outColor=8'h00, palette defaults restored, state IDLE.
